// File: rtl/clk_rate_detector_pkg.sv
// Shared types, defaults and period-decoding helpers for the clock rate detector.
package clk_rate_pkg;

    localparam int MAX_N_DEF       = 11;
    localparam int CNT_W_DEF       = 13;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FIRST   = 2'd1,
        MEASURE = 2'd2,
        LOCKED  = 2'd3
    } state_e;

    function automatic logic is_pow2(input logic [15:0] p);
        return (p != 16'd0) && ((p & (p - 16'd1)) == 16'd0);
    endfunction

    // Index of the highest set bit; only meaningful when is_pow2(p) holds.
    function automatic logic [3:0] log2_exact(input logic [15:0] p);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (p[i]) r = i[3:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/clk_rate_detector_if.sv
// Measured clock input and rate report outputs of the clock rate detector.
interface clk_rate_detector_if;
    import clk_rate_pkg::*;

    logic       measClk;
    logic [3:0] nOut;
    logic       valid;
    logic       err;
    logic       noClk;
    logic       update;
    state_e     state;

    // valid and noClk are levels; err and update are single-cycle pulses, and
    // nOut is only meaningful as "last locked exponent" when valid is low.
    modport slave (
        input  measClk,
        output nOut, valid, err, noClk, update, state
    );

    modport master (
        output measClk,
        input  nOut, valid, err, noClk, update, state
    );

endinterface

// File: rtl/clk_rate_detector_sync_ff.sv
// Multi-stage synchroniser bringing an asynchronous level into the local clock domain.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            chain_q <= '0;
        end else begin
            chain_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                chain_q[i] <= chain_q[i-1];
            end
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/clk_rate_detector.sv
// Measures the period of a power-of-two divided clock and reports its exponent once stable.
module clk_rate_detector
    import clk_rate_pkg::*;
#(
    parameter int MAX_N       = MAX_N_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic               inClk,
    input  logic               rstN,
    clk_rate_detector_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(1) << (MAX_N + 1);
    localparam logic [3:0]       MAX_K   = 4'(MAX_N);

    logic             s, s_prev_q, rise, fall, sat;
    logic [CNT_W-1:0] cnt_q, cnt_d, hi_run_q, hi_run_d, hi_cap_q, hi_cap_d;
    logic [3:0]       k;
    logic             bad;

    state_e     state_q, state_d;
    logic [3:0] kprev_q, kprev_d, nout_q, nout_d;
    logic       valid_q, valid_d, err_q, err_d, noclk_q, noclk_d, update_q, update_d;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clk_i   (inClk),
        .rst_n_i (rstN),
        .d_i     (bus.measClk),
        .q_o     (s)
    );

    assign rise = s & ~s_prev_q;
    assign fall = ~s & s_prev_q;
    // A rise landing on the saturated count still counts as an edge; its period decodes as bad.
    assign sat  = (cnt_q == CNT_SAT) && !rise;

    assign cnt_d    = rise ? CNT_ONE : ((cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_ONE);
    assign hi_run_d = rise ? CNT_ONE
                    : ((s && hi_run_q != CNT_SAT) ? hi_run_q + CNT_ONE : hi_run_q);
    assign hi_cap_d = fall ? hi_run_q : hi_cap_q;

    assign k   = log2_exact(16'(cnt_q));
    assign bad = !is_pow2(16'(cnt_q)) || (k == 4'd0) || (k > MAX_K)
               || (hi_cap_q != (cnt_q >> 1));

    always_ff @(posedge inClk or negedge rstN) begin
        if (!rstN) begin
            s_prev_q <= 1'b0;
            cnt_q    <= '0;
            hi_run_q <= '0;
            hi_cap_q <= '0;
            state_q  <= IDLE;
            kprev_q  <= 4'd0;
            nout_q   <= 4'd0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            noclk_q  <= 1'b0;
            update_q <= 1'b0;
        end else begin
            s_prev_q <= s;
            cnt_q    <= cnt_d;
            hi_run_q <= hi_run_d;
            hi_cap_q <= hi_cap_d;
            state_q  <= state_d;
            kprev_q  <= kprev_d;
            nout_q   <= nout_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            noclk_q  <= noclk_d;
            update_q <= update_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        kprev_d  = kprev_q;
        nout_d   = nout_q;
        valid_d  = valid_q;
        noclk_d  = noclk_q;
        err_d    = 1'b0;
        update_d = 1'b0;

        if (rise) noclk_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (rise) state_d = FIRST;
            end
            FIRST: begin
                if (rise) begin
                    if (bad) begin
                        err_d = 1'b1;
                    end else begin
                        kprev_d = k;
                        state_d = MEASURE;
                    end
                end
            end
            MEASURE: begin
                if (rise) begin
                    if (bad) begin
                        err_d   = 1'b1;
                        state_d = FIRST;
                    end else if (k == kprev_q) begin
                        nout_d   = k;
                        valid_d  = 1'b1;
                        update_d = 1'b1;
                        state_d  = LOCKED;
                    end else begin
                        kprev_d = k;
                    end
                end
            end
            LOCKED: begin
                if (rise && (bad || k != kprev_q)) begin
                    valid_d = 1'b0;
                    err_d   = 1'b1;
                    state_d = MEASURE;
                    if (!bad) kprev_d = k;
                end
            end
            default: state_d = IDLE;
        endcase

        if (sat) begin
            noclk_d  = 1'b1;
            valid_d  = 1'b0;
            err_d    = 1'b0;
            update_d = 1'b0;
            state_d  = IDLE;
        end
    end

    assign bus.nOut   = nout_q;
    assign bus.valid  = valid_q;
    assign bus.err    = err_q;
    assign bus.noClk  = noclk_q;
    assign bus.update = update_q;
    assign bus.state  = state_q;

endmodule
